// File: rtl/adder12s_sched.sv
// adder12s_sched: collects A/B sample streams into 8-sample vectors, issues them round-robin
// to a 5-stage adder tree and returns each sum tagged with its requester id.
module adder12s_sched #(
    parameter int DW      = 12,
    parameter int SW      = 15,
    parameter int ADD_LAT = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [DW-1:0]   a_data,
    input  logic            a_valid,
    output logic            a_ready,
    input  logic [DW-1:0]   b_data,
    input  logic            b_valid,
    output logic            b_ready,
    output logic [8*DW-1:0] add_n,
    output logic            add_issue,
    input  logic [SW-1:0]   add_sum,
    output logic            res_valid,
    output logic            res_id,
    output logic [SW-1:0]   res_sum,
    output logic            busy
);
    logic [8*DW-1:0]    vec_q [2];
    logic [2:0]         idx_q [2];
    logic [DW-1:0]      din [2];
    logic [1:0]         full_q, vld, acc;
    logic               rr_q, gnt_v, gnt_id, issue_id_q;
    logic [ADD_LAT-1:0] tv_q, tid_q;
    logic [8*DW-1:0]    add_n_q;
    logic               add_issue_q, res_valid_q, res_id_q;
    logic [SW-1:0]      res_sum_q;

    assign din[0] = a_data;
    assign din[1] = b_data;
    assign vld    = {b_valid, a_valid};
    assign acc    = vld & ~full_q;

    always_comb begin
        gnt_v  = |full_q;
        gnt_id = (&full_q) ? rr_q : full_q[1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int s = 0; s < 2; s++) begin
                vec_q[s] <= '0;
                idx_q[s] <= '0;
            end
            full_q      <= '0;
            rr_q        <= 1'b0;
            add_n_q     <= '0;
            add_issue_q <= 1'b0;
            issue_id_q  <= 1'b0;
            tv_q        <= '0;
            tid_q       <= '0;
            res_valid_q <= 1'b0;
            res_id_q    <= 1'b0;
            res_sum_q   <= '0;
        end else begin
            for (int s = 0; s < 2; s++) begin
                if (acc[s]) begin
                    vec_q[s][idx_q[s]*DW +: DW] <= din[s];
                    idx_q[s] <= idx_q[s] + 3'd1;
                    if (idx_q[s] == 3'd7) full_q[s] <= 1'b1;
                end
            end
            // a granted collector is full, so it never accepts in the same cycle
            if (gnt_v) begin
                add_n_q        <= vec_q[gnt_id];
                full_q[gnt_id] <= 1'b0;
                rr_q           <= !gnt_id;
            end
            add_issue_q <= gnt_v;
            issue_id_q  <= gnt_id;
            tv_q        <= {tv_q[ADD_LAT-2:0], add_issue_q};
            tid_q       <= {tid_q[ADD_LAT-2:0], issue_id_q};
            res_valid_q <= tv_q[ADD_LAT-1];
            if (tv_q[ADD_LAT-1]) begin
                res_sum_q <= add_sum;
                res_id_q  <= tid_q[ADD_LAT-1];
            end
        end
    end

    assign a_ready   = !full_q[0];
    assign b_ready   = !full_q[1];
    assign add_n     = add_n_q;
    assign add_issue = add_issue_q;
    assign res_valid = res_valid_q;
    assign res_id    = res_id_q;
    assign res_sum   = res_sum_q;
    assign busy      = (|full_q) | (|idx_q[0]) | (|idx_q[1]) | add_issue_q | (|tv_q);
endmodule

// File: tb/tb_adder12s_sched.sv
// tb_adder12s_sched: directed and randomized checks of adder12s_sched against a
// stream-level scoreboard fed by the accepted samples of each requester.
module tb_adder12s_sched;
    logic        clk = 0, rst = 0;
    logic [11:0] a_data = 0, b_data = 0;
    logic        a_valid = 0, b_valid = 0, a_ready, b_ready;
    logic [95:0] add_n;
    logic        add_issue;
    logic [14:0] add_sum;
    logic        res_valid, res_id;
    logic [14:0] res_sum;
    logic        busy;
    int checks = 0, failures = 0, cyc = 0;

    typedef struct { logic [95:0] v; logic [14:0] s; int fe; } pend_t;
    typedef struct { logic id; logic [14:0] s; int c; } res_t;
    pend_t pa[$], pb[$];
    res_t  rq[$], res_log[$];
    logic  iss_ids[$];
    logic [95:0] va, vb;
    int sa = 0, sb = 0, ca = 0, cb = 0;
    int n_issue = 0, a_low = 0, n_acc_a = 0;
    logic ea, eb, gid, nxt = 0;
    pend_t hd;
    res_t  r;
    logic [14:0] pipe [5];

    adder12s_sched dut (
        .clk(clk), .rst(rst),
        .a_data(a_data), .a_valid(a_valid), .a_ready(a_ready),
        .b_data(b_data), .b_valid(b_valid), .b_ready(b_ready),
        .add_n(add_n), .add_issue(add_issue), .add_sum(add_sum),
        .res_valid(res_valid), .res_id(res_id), .res_sum(res_sum), .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] tree(input logic [95:0] n);
        logic [14:0] s = '0;
        for (int k = 0; k < 8; k++) s = s + {{3{n[k*12+11]}}, n[k*12 +: 12]};
        return s;
    endfunction

    // behavioural 5-stage adder tree
    always @(posedge clk) begin
        cyc     <= cyc + 1;
        pipe[0] <= tree(add_n);
        for (int k = 1; k < 5; k++) pipe[k] <= pipe[k-1];
    end
    assign add_sum = pipe[4];

    always @(negedge clk) begin
        if (rst) begin
            pa.delete(); pb.delete(); rq.delete();
            ca = 0; cb = 0; sa = 0; sb = 0; nxt = 0;
        end else begin
            ea = pa.size() > 0 && pa[0].fe < cyc;
            eb = pb.size() > 0 && pb[0].fe < cyc;
            if (add_issue) begin
                checks++;
                if (!ea && !eb) begin
                    failures++;
                    $display("FAIL issue_unexpected cyc=%0d got add_issue=1 want 0", cyc);
                end else begin
                    gid = (ea && eb) ? nxt : eb;
                    hd  = gid ? pb[0] : pa[0];
                    if (gid) void'(pb.pop_front()); else void'(pa.pop_front());
                    nxt = !gid;
                    iss_ids.push_back(gid);
                    n_issue++;
                    checks++;
                    if (add_n !== hd.v) begin
                        failures++;
                        $display("FAIL issue_vector cyc=%0d side=%0d got %h want %h", cyc, gid, add_n, hd.v);
                    end
                    r.id = gid; r.s = hd.s; r.c = cyc;
                    rq.push_back(r);
                end
            end else if (ea || eb) begin
                checks++; failures++;
                $display("FAIL grant_missing cyc=%0d got add_issue=0 want 1", cyc);
            end
            if (res_valid) begin
                checks++;
                if (rq.size() == 0) begin
                    failures++;
                    $display("FAIL res_unexpected cyc=%0d got res_valid=1 want 0", cyc);
                end else begin
                    if (res_id !== rq[0].id || res_sum !== rq[0].s || cyc != rq[0].c + 6) begin
                        failures++;
                        $display("FAIL result cyc=%0d got id=%0d sum=%h want id=%0d sum=%h cyc=%0d",
                                 cyc, res_id, res_sum, rq[0].id, rq[0].s, rq[0].c + 6);
                    end
                    r.id = res_id; r.s = res_sum; r.c = cyc;
                    res_log.push_back(r);
                    void'(rq.pop_front());
                end
            end else if (rq.size() > 0 && cyc >= rq[0].c + 6) begin
                checks++; failures++;
                $display("FAIL res_missing cyc=%0d got res_valid=0 want 1", cyc);
                void'(rq.pop_front());
            end
            if (a_valid && a_ready) begin
                va[ca*12 +: 12] = a_data; sa += $signed(a_data); ca++; n_acc_a++;
                if (ca == 8) begin
                    hd.v = va; hd.s = 15'(sa); hd.fe = cyc + 1;
                    pa.push_back(hd); ca = 0; sa = 0;
                end
            end
            if (b_valid && b_ready) begin
                vb[cb*12 +: 12] = b_data; sb += $signed(b_data); cb++;
                if (cb == 8) begin
                    hd.v = vb; hd.s = 15'(sb); hd.fe = cyc + 1;
                    pb.push_back(hd); cb = 0; sb = 0;
                end
            end
            if (!a_ready) a_low++;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input bit side, input logic [11:0] d);
        int g = 0;
        bit ok;
        if (side) begin b_valid = 1; b_data = d; end
        else begin a_valid = 1; a_data = d; end
        do begin
            @(negedge clk);
            ok = side ? b_ready : a_ready;
            @(posedge clk); #1;
            g++;
        end while (!ok && g < 50);
        if (!ok) begin
            checks++; failures++;
            $display("FAIL push_timeout side=%0d got ready=0 want 1", side);
        end
    endtask

    task automatic test_reset;
        #2 rst = 1;
        #1;
        checks++;
        if ({add_n, add_issue, res_valid, res_id, res_sum, busy} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got %h want 0", {add_n, add_issue, res_valid, res_id, res_sum, busy});
        end
        @(posedge clk); #1 rst = 0;
        @(negedge clk);
        checks++;
        if ({a_ready, b_ready, busy} !== 3'b110) begin
            failures++;
            $display("FAIL reset_ready got %b want 110", {a_ready, b_ready, busy});
        end
        idle(1);
    endtask

    task automatic test_row_stream;
        logic [95:0] ev;
        n_issue = 0; a_low = 0; res_log.delete();
        for (int k = 1; k <= 8; k++) begin
            push(0, 12'(k));
            ev[(k-1)*12 +: 12] = 12'(k);
        end
        a_valid = 0;
        idle(12);
        checks++;
        if (n_issue != 1 || a_low != 1) begin
            failures++;
            $display("FAIL row_counts got issues=%0d ready_low=%0d want 1 1", n_issue, a_low);
        end
        checks++;
        if (add_n !== ev) begin
            failures++;
            $display("FAIL row_add_n got %h want %h", add_n, ev);
        end
        checks++;
        if (res_log.size() != 1 || res_log[0].id !== 1'b0 || res_log[0].s !== 15'd36) begin
            failures++;
            $display("FAIL row_result got n=%0d sum=%0d want n=1 id=0 sum=36", res_log.size(),
                     res_log.size() ? res_log[0].s : 15'd0);
        end
    endtask

    task automatic test_range;
        res_log.delete();
        for (int k = 0; k < 8; k++) push(1, 12'h800);
        b_valid = 0;
        idle(12);
        checks++;
        if (res_log.size() != 1 || res_log[0].id !== 1'b1 || res_log[0].s !== 15'h4000) begin
            failures++;
            $display("FAIL range_min got res_id=%0d res_sum=%h want 1 4000", res_id, res_sum);
        end
        res_log.delete();
        for (int k = 0; k < 8; k++) push(1, 12'h7ff);
        b_valid = 0;
        idle(12);
        checks++;
        if (res_log.size() != 1 || res_log[0].id !== 1'b1 || res_log[0].s !== 15'd16376) begin
            failures++;
            $display("FAIL range_max got res_id=%0d res_sum=%0d want 1 16376", res_id, res_sum);
        end
    endtask

    task automatic test_simultaneous;
        iss_ids.delete(); res_log.delete();
        fork
            for (int k = 0; k < 8; k++) push(0, 12'd1);
            for (int k = 0; k < 8; k++) push(1, 12'd2);
        join
        a_valid = 0; b_valid = 0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL sim_busy got %b want 1", busy);
        end
        idle(12);
        checks++;
        if (iss_ids.size() != 2 || iss_ids[0] !== 1'b0 || iss_ids[1] !== 1'b1) begin
            failures++;
            $display("FAIL sim_order got n=%0d want A then B", iss_ids.size());
        end
        checks++;
        if (res_log.size() != 2 || res_log[0].id !== 1'b0 || res_log[0].s !== 15'd8 ||
            res_log[1].id !== 1'b1 || res_log[1].s !== 15'd16 || res_log[1].c != res_log[0].c + 1) begin
            failures++;
            $display("FAIL sim_results got n=%0d want (0,8) then (1,16) back-to-back", res_log.size());
        end
        for (int k = 0; k < 8; k++) push(0, 12'd5);
        a_valid = 0;
        idle(12);
        iss_ids.delete();
        fork
            for (int k = 0; k < 8; k++) push(0, 12'd3);
            for (int k = 0; k < 8; k++) push(1, 12'd4);
        join
        a_valid = 0; b_valid = 0;
        idle(12);
        checks++;
        if (iss_ids.size() != 2 || iss_ids[0] !== 1'b1 || iss_ids[1] !== 1'b0) begin
            failures++;
            $display("FAIL sim_rr got n=%0d first=%0d want B then A", iss_ids.size(),
                     iss_ids.size() ? iss_ids[0] : 1'b0);
        end
    endtask

    task automatic test_hold;
        logic [11:0] v [16];
        int s0 = 0, s1 = 0;
        int base = $urandom_range(0, 4095);
        n_acc_a = 0; n_issue = 0; a_low = 0; res_log.delete();
        for (int k = 0; k < 16; k++) begin
            v[k] = 12'(base + k * 251);
            if (k < 8) s0 += $signed(v[k]); else s1 += $signed(v[k]);
        end
        for (int k = 0; k < 16; k++) push(0, v[k]);
        a_valid = 0;
        idle(14);
        checks++;
        if (n_acc_a != 16 || n_issue != 2 || a_low != 2) begin
            failures++;
            $display("FAIL hold_counts got acc=%0d issues=%0d ready_low=%0d want 16 2 2", n_acc_a, n_issue, a_low);
        end
        checks++;
        if (res_log.size() != 2 || res_log[0].s !== 15'(s0) || res_log[1].s !== 15'(s1)) begin
            failures++;
            $display("FAIL hold_sums got n=%0d want sums %h %h", res_log.size(), 15'(s0), 15'(s1));
        end
    endtask

    task automatic test_reset_inflight;
        fork
            for (int k = 0; k < 8; k++) push(0, 12'd7);
            begin
                for (int k = 0; k < 8; k++) push(1, 12'd9);
                for (int k = 0; k < 4; k++) push(1, 12'hf00);
            end
        join
        a_valid = 0; b_valid = 0;
        rst = 1;
        #1;
        checks++;
        if ({add_n, res_valid, res_sum, busy} !== '0) begin
            failures++;
            $display("FAIL inflight_reset got %h want 0", {add_n, res_valid, res_sum, busy});
        end
        idle(2);
        rst = 0;
        res_log.delete();
        idle(15);
        checks++;
        if (res_log.size() != 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL inflight_quiet got results=%0d busy=%b want 0 0", res_log.size(), busy);
        end
        for (int k = 0; k < 8; k++) push(1, 12'(100 + k));
        b_valid = 0;
        idle(12);
        checks++;
        if (res_log.size() != 1 || res_log[0].id !== 1'b1 || res_log[0].s !== 15'd828) begin
            failures++;
            $display("FAIL inflight_fresh got n=%0d res_sum=%0d want 1 828", res_log.size(), res_sum);
        end
    endtask

    task automatic test_random;
        bit ka, kb;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            ka = a_valid && a_ready;
            kb = b_valid && b_ready;
            @(posedge clk); #1;
            if (ka || !a_valid) begin a_valid = $urandom_range(0, 3) != 0; a_data = 12'($urandom); end
            if (kb || !b_valid) begin b_valid = $urandom_range(0, 3) != 0; b_data = 12'($urandom); end
        end
        a_valid = 0; b_valid = 0;
        idle(20);
        checks++;
        if (pa.size() + pb.size() + rq.size() != 0) begin
            failures++;
            $display("FAIL random_drain got pending=%0d want 0", pa.size() + pb.size() + rq.size());
        end
        checks++;
        if (busy !== (ca != 0 || cb != 0)) begin
            failures++;
            $display("FAIL random_busy got %b want %b", busy, ca != 0 || cb != 0);
        end
    endtask

    initial begin
        test_reset;
        test_row_stream;
        test_range;
        test_simultaneous;
        test_hold;
        test_reset_inflight;
        test_random;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end
endmodule
